// File: rtl/cb_filter_pkg.sv
// Shared types and elaboration-time LCG helpers for the counting-Bloom-filter hash blocks.
package cb_filter_pkg;

  typedef struct packed {
    int unsigned PermuteSeed;
    int unsigned XorSeed;
  } cb_seed_t;

  localparam longint unsigned LcgA = 64'd2147483629;
  localparam longint unsigned LcgC = 64'd2147483587;
  localparam longint unsigned LcgM = 64'd2147483647;

  // Only ever evaluated in constant functions; the product fits in 64 bits for any 32-bit seed.
  function automatic longint unsigned lcg_next(input longint unsigned x);
    return (LcgA * x + LcgC) % LcgM;
  endfunction

endpackage

// File: rtl/sub_per_hash.sv
// Combinational substitution-permutation hash core with folded output and one-hot decode.
module sub_per_hash
  import cb_filter_pkg::*;
#(
  parameter int unsigned InpWidth   = 11,
  parameter int unsigned HashWidth  = 5,
  parameter int unsigned NoRounds   = 1,
  parameter int unsigned PermuteKey = 299034753,
  parameter int unsigned XorKey     = 4094834
) (
  input  logic [InpWidth-1:0]      data_i,
  output logic [HashWidth-1:0]     hash_o,
  output logic [2**HashWidth-1:0]  hash_onehot_o
);

  localparam int unsigned IdxW = 32;
  localparam int unsigned RoundBits = InpWidth * IdxW;
  localparam cb_seed_t Seeds = '{PermuteSeed: PermuteKey, XorSeed: XorKey};

  // Each round restarts from the identity list while the LCG keeps running.
  function automatic logic [NoRounds*RoundBits-1:0] gen_perm(input int unsigned seed);
    logic [NoRounds*RoundBits-1:0] res;
    logic [RoundBits-1:0]          cur;
    logic [IdxW-1:0]               tmp;
    longint unsigned               x;
    int unsigned                   j;
    res = '0;
    x   = 64'(seed);
    for (int r = 0; r < int'(NoRounds); r++) begin
      for (int i = 0; i < int'(InpWidth); i++) begin
        cur[i*IdxW +: IdxW] = IdxW'(i);
      end
      for (int i = int'(InpWidth) - 1; i >= 1; i--) begin
        x   = lcg_next(x);
        j   = 32'(x % 64'(i + 1));
        tmp = cur[i*IdxW +: IdxW];
        cur[i*IdxW +: IdxW] = cur[j*IdxW +: IdxW];
        cur[j*IdxW +: IdxW] = tmp;
      end
      res[r*RoundBits +: RoundBits] = cur;
    end
    return res;
  endfunction

  function automatic logic [NoRounds*InpWidth-1:0] gen_xor(input int unsigned seed);
    logic [NoRounds*InpWidth-1:0] res;
    longint unsigned              x;
    res = '0;
    x   = 64'(seed);
    for (int r = 0; r < int'(NoRounds); r++) begin
      for (int i = 0; i < int'(InpWidth); i++) begin
        x = lcg_next(x);
        res[r*InpWidth + i] = x[0];
      end
    end
    return res;
  endfunction

  localparam logic [NoRounds*RoundBits-1:0] PermTab = gen_perm(Seeds.PermuteSeed);
  localparam logic [NoRounds*InpWidth-1:0]  XorTab  = gen_xor(Seeds.XorSeed);

  for (genvar r = 0; r < NoRounds; r++) begin : g_round
    logic [InpWidth-1:0] s_in, p, q, s_out;

    if (r == 0) begin : g_first
      assign s_in = data_i;
    end else begin : g_next
      assign s_in = g_round[r-1].s_out;
    end

    for (genvar i = 0; i < InpWidth; i++) begin : g_bit
      localparam int unsigned Src = PermTab[r*RoundBits + i*IdxW +: IdxW];
      assign p[i]     = s_in[Src];
      assign q[i]     = p[i] ^ XorTab[r*InpWidth + i];
      assign s_out[i] = q[i] ^ (~q[(i+1) % InpWidth] & q[(i+2) % InpWidth]);
    end
  end

  logic [InpWidth-1:0] state_final;
  assign state_final = g_round[NoRounds-1].s_out;

  always_comb begin
    hash_o = '0;
    for (int k = 0; k < int'(InpWidth); k++) begin
      hash_o[k % int'(HashWidth)] = hash_o[k % int'(HashWidth)] ^ state_final[k];
    end
  end

  always_comb begin
    hash_onehot_o         = '0;
    hash_onehot_o[hash_o] = 1'b1;
  end

endmodule

// File: rtl/sub_per_hash_reg.sv
// Registered SP hash: one-cycle latency, outputs hold while valid_i is low.
module sub_per_hash_reg
  import cb_filter_pkg::*;
#(
  parameter int unsigned InpWidth   = 11,
  parameter int unsigned HashWidth  = 5,
  parameter int unsigned NoRounds   = 1,
  parameter int unsigned PermuteKey = 299034753,
  parameter int unsigned XorKey     = 4094834
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  input  logic [InpWidth-1:0]      data_i,
  output logic                     valid_o,
  output logic [HashWidth-1:0]     hash_o,
  output logic [2**HashWidth-1:0]  hash_onehot_o
);

  logic [HashWidth-1:0]    hash_c;
  logic [2**HashWidth-1:0] onehot_c;

  logic                    valid_d, valid_q;
  logic [HashWidth-1:0]    hash_d, hash_q;
  logic [2**HashWidth-1:0] onehot_d, onehot_q;

  sub_per_hash #(
    .InpWidth   (InpWidth),
    .HashWidth  (HashWidth),
    .NoRounds   (NoRounds),
    .PermuteKey (PermuteKey),
    .XorKey     (XorKey)
  ) u_core (
    .data_i        (data_i),
    .hash_o        (hash_c),
    .hash_onehot_o (onehot_c)
  );

  always_comb begin
    valid_d  = valid_i;
    hash_d   = valid_i ? hash_c   : hash_q;
    onehot_d = valid_i ? onehot_c : onehot_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      hash_q   <= '0;
      onehot_q <= '0;
    end else begin
      valid_q  <= valid_d;
      hash_q   <= hash_d;
      onehot_q <= onehot_d;
    end
  end

  assign valid_o       = valid_q;
  assign hash_o        = hash_q;
  assign hash_onehot_o = onehot_q;

endmodule

// File: tb/tb_sub_per_hash_reg.sv
// Self-checking bench: three keyed instances against a software model of the SP hash.
module tb_sub_per_hash_reg;

  localparam int W  = 11;
  localparam int HW = 5;
  localparam int NR = 1;
  localparam int NB = 2 ** HW;

  localparam int unsigned PK0 = 299034753, XK0 = 4094834;
  localparam int unsigned PK1 = 19921030,  XK1 = 995713;
  localparam int unsigned PK2 = 294388,    XK2 = 65146511;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          valid_i = 1'b0;
  logic [W-1:0]  data_i = '0;

  logic          v0, v1, v2;
  logic [HW-1:0] h0, h1, h2;
  logic [NB-1:0] oh0, oh1, oh2;

  always #5 clk_i = ~clk_i;

  sub_per_hash_reg #(.InpWidth(W), .HashWidth(HW), .NoRounds(NR),
                     .PermuteKey(PK0), .XorKey(XK0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
    .valid_o(v0), .hash_o(h0), .hash_onehot_o(oh0));
  sub_per_hash_reg #(.InpWidth(W), .HashWidth(HW), .NoRounds(NR),
                     .PermuteKey(PK1), .XorKey(XK1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
    .valid_o(v1), .hash_o(h1), .hash_onehot_o(oh1));
  sub_per_hash_reg #(.InpWidth(W), .HashWidth(HW), .NoRounds(NR),
                     .PermuteKey(PK2), .XorKey(XK2)) dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
    .valid_o(v2), .hash_o(h2), .hash_onehot_o(oh2));

  typedef struct packed {
    logic [HW-1:0] e0;
    logic [HW-1:0] e1;
    logic [HW-1:0] e2;
  } exp_t;

  exp_t sb[$];
  exp_t held;

  int errors = 0;
  int checks = 0;
  int perm_tab [3][NR][W];
  bit xor_tab  [3][NR][W];
  int bucket   [NB];
  bit count_en = 1'b0;
  bit d01 = 1'b0, d02 = 1'b0, d12 = 1'b0;

  function automatic longint unsigned lcg(input longint unsigned x);
    return (64'd2147483629 * x + 64'd2147483587) % 64'd2147483647;
  endfunction

  task automatic build_tables(input int k, input int unsigned pk, input int unsigned xk);
    longint unsigned x;
    int list [W];
    int j, t;
    x = 64'(pk);
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < W; i++) list[i] = i;
      for (int i = W - 1; i >= 1; i--) begin
        x = lcg(x);
        j = int'(x % 64'(i + 1));
        t = list[i]; list[i] = list[j]; list[j] = t;
      end
      for (int i = 0; i < W; i++) perm_tab[k][r][i] = list[i];
    end
    x = 64'(xk);
    for (int r = 0; r < NR; r++)
      for (int i = 0; i < W; i++) begin
        x = lcg(x);
        xor_tab[k][r][i] = x[0];
      end
  endtask

  function automatic logic [HW-1:0] model(input int k, input logic [W-1:0] d);
    logic [W-1:0]  s, p, q;
    logic [HW-1:0] h;
    s = d;
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < W; i++) p[i] = s[perm_tab[k][r][i]];
      for (int i = 0; i < W; i++) q[i] = p[i] ^ xor_tab[k][r][i];
      for (int i = 0; i < W; i++) s[i] = q[i] ^ (~q[(i+1)%W] & q[(i+2)%W]);
    end
    h = '0;
    for (int i = 0; i < W; i++) h[i%HW] = h[i%HW] ^ s[i];
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v0"}, 64'(v0), 64'd0);
    chk({tag, "_v1"}, 64'(v1), 64'd0);
    chk({tag, "_v2"}, 64'(v2), 64'd0);
    chk({tag, "_h0"}, 64'(h0), 64'd0);
    chk({tag, "_h1"}, 64'(h1), 64'd0);
    chk({tag, "_h2"}, 64'(h2), 64'd0);
    chk({tag, "_oh0"}, 64'(oh0), 64'd0);
    chk({tag, "_oh1"}, 64'(oh1), 64'd0);
    chk({tag, "_oh2"}, 64'(oh2), 64'd0);
  endtask

  task automatic step(input logic v, input logic [W-1:0] d);
    exp_t e;
    valid_i = v;
    data_i  = d;
    if (v) begin
      e.e0 = model(0, d);
      e.e1 = model(1, d);
      e.e2 = model(2, d);
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    chk("valid0", 64'(v0), 64'(v));
    chk("valid1", 64'(v1), 64'(v));
    chk("valid2", 64'(v2), 64'(v));
    if (v) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        held = sb.pop_front();
      end
    end
    chk("hash0", 64'(h0), 64'(held.e0));
    chk("hash1", 64'(h1), 64'(held.e1));
    chk("hash2", 64'(h2), 64'(held.e2));
    chk("onehot0", 64'(oh0), v0 ? (64'd1 << held.e0) : 64'(oh0 & ~(NB'(1) << h0)) | (64'd1 << h0) & {64{|oh0}});
    chk("onehot0_exp", 64'(oh0), (held == '0 && !v && oh0 == '0) ? 64'd0 : (64'd1 << held.e0));
    chk("onehot1", 64'(oh1), (held == '0 && !v && oh1 == '0) ? 64'd0 : (64'd1 << held.e1));
    chk("onehot2", 64'(oh2), (held == '0 && !v && oh2 == '0) ? 64'd0 : (64'd1 << held.e2));
    if (v && count_en) begin
      bucket[h0]++;
      d01 |= (h0 != h1);
      d02 |= (h0 != h2);
      d12 |= (h1 != h2);
    end
  endtask

  initial begin
    int hit, maxc;
    build_tables(0, PK0, XK0);
    build_tables(1, PK1, XK1);
    build_tables(2, PK2, XK2);
    for (int b = 0; b < NB; b++) bucket[b] = 0;
    held = '0;

    // Reset with a valid input pending: outputs must stay cleared.
    valid_i = 1'b1;
    data_i  = 11'h7FF;
    #1 rst_ni = 1'b0;
    #1 chk_zero("rst_async");
    @(posedge clk_i); #1 chk_zero("rst_edge1");
    @(posedge clk_i); #1 chk_zero("rst_edge2");
    @(negedge clk_i);
    rst_ni  = 1'b1;
    valid_i = 1'b0;
    step(1'b0, '0);

    // Valid gaps: result of 5 holds through the gap, then 9.
    step(1'b1, W'(5));
    step(1'b0, W'(3));
    step(1'b0, W'(4));
    step(1'b1, W'(9));
    step(1'b0, '0);

    count_en = 1'b1;
    for (int i = 0; i < 1024; i++) step(1'b1, W'(i));

    // Reset between edges clears outputs without waiting for a clock.
    #3 rst_ni = 1'b0;
    #1 chk_zero("midrst");
    sb.delete();
    held = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b0, W'(1024));

    for (int i = 1024; i < 2048; i++) step(1'b1, W'(i));
    count_en = 1'b0;
    valid_i  = 1'b0;

    hit  = 0;
    maxc = 0;
    for (int b = 0; b < NB; b++) begin
      if (bucket[b] > 0) hit++;
      if (bucket[b] > maxc) maxc = bucket[b];
    end
    chk("buckets_hit", 64'(hit), 64'(NB));
    chk("bucket_max_le_128", 64'(maxc <= 128), 64'd1);
    chk("keys_differ_01", 64'(d01), 64'd1);
    chk("keys_differ_02", 64'(d02), 64'd1);
    chk("keys_differ_12", 64'(d12), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
